// File: rtl/game_pkg.sv
// Shared constants and types for the LED-matrix dodge game.
package game_pkg;

  localparam int unsigned ROWS             = 16;
  localparam int unsigned COLS             = 16;
  localparam int unsigned PLAYER_ROW       = 14;
  localparam int unsigned PLAYER_START_COL = 7;

  typedef logic [15:0][15:0] pixel_grid_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    CHECK,
    LOST
  } game_state_t;

endpackage

// File: rtl/pixel_collide.sv
// Combinational red/green overlap detector over a full pixel grid.
module pixel_collide
  import game_pkg::*;
(
  input  pixel_grid_t red_i,
  input  pixel_grid_t grn_i,
  output logic        hit_o
);

  // Any pixel lit in both colours is a collision.
  always_comb begin
    hit_o = |(red_i & grn_i);
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: obstacle field shifting, player movement, scoring and
// collision-driven game over for the 16x16 red/green LED matrix.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic              Clock,
  input  logic              reset,
  input  logic              start,
  input  logic              left,
  input  logic              right,
  input  logic [15:0]       obstacle_row,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels,
  output logic              lost,
  output logic              running,
  output logic [7:0]        score,
  output logic              row_req
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  START_COL = 4'(PLAYER_START_COL);

  game_state_t state_q, state_d;
  logic [15:0] tick_q, tick_d;
  pixel_grid_t red_q, red_d;
  pixel_grid_t grn;
  logic [3:0]  col_q, col_d;
  logic [7:0]  score_q, score_d;
  logic        hit;

  // Sprite is a single pixel in the player row at the current column.
  always_comb begin
    grn                    = '0;
    grn[PLAYER_ROW][col_q] = 1'b1;
  end

  pixel_collide u_collide (
    .red_i (red_q),
    .grn_i (grn),
    .hit_o (hit)
  );

  // Next-state logic for the FSM, tick counter, field, player and score.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    red_d   = red_q;
    col_d   = col_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        red_d   = '0;
        col_d   = START_COL;
        score_d = '0;
        tick_d  = '0;
        if (start) state_d = RUN;
      end
      RUN: begin
        // Collision wins over both the move and the tick so the losing
        // frame stays exactly as it was when the overlap appeared.
        if (hit) begin
          state_d = LOST;
        end else begin
          if (left && !right && col_q != 4'd0) begin
            col_d = col_q - 4'd1;
          end else if (right && !left && col_q != 4'd15) begin
            col_d = col_q + 4'd1;
          end
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = STEP;
          end else begin
            tick_d = tick_q + 16'd1;
          end
        end
      end
      STEP: begin
        red_d   = {red_q[14:0], obstacle_row};
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = hit ? LOST : RUN;
      end
      LOST: begin
        // Clear on the way out so IDLE shows a blank field immediately.
        if (start) begin
          red_d   = '0;
          col_d   = START_COL;
          score_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      red_q   <= '0;
      col_q   <= START_COL;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      red_q   <= red_d;
      col_q   <= col_d;
      score_q <= score_d;
    end
  end

  // Moore outputs decoded from registered state.
  always_comb begin
    RedPixels = red_q;
    GrnPixels = grn;
    lost      = (state_q == LOST);
    running   = (state_q == RUN) || (state_q == STEP) || (state_q == CHECK);
    score     = score_q;
    row_req   = (state_q == STEP);
  end

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  import game_pkg::*;

  localparam int unsigned TD = 4;

  logic              Clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              left = 1'b0;
  logic              right = 1'b0;
  logic [15:0]       obstacle_row = '0;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic              lost;
  logic              running;
  logic [7:0]        score;
  logic              row_req;

  int checks = 0;
  int errors = 0;

  game_sequencer #(.TICK_DIV(TD)) dut (
    .Clock        (Clock),
    .reset        (reset),
    .start        (start),
    .left         (left),
    .right        (right),
    .obstacle_row (obstacle_row),
    .RedPixels    (RedPixels),
    .GrnPixels    (GrnPixels),
    .lost         (lost),
    .running      (running),
    .score        (score),
    .row_req      (row_req)
  );

  always #5 Clock = ~Clock;

  // Reference model: mode 0 idle / 1 playing / 2 lost; m_cyc is the
  // position inside one step period (0..TD-1 waiting, TD shifting, TD+1 judging).
  int          m_mode, m_cyc, m_col, m_score;
  logic [15:0] m_field [16];

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_col = 7; m_score = 0;
    for (int i = 0; i < 16; i++) m_field[i] = '0;
  endtask

  task automatic model_step(input logic s, input logic l, input logic r, input logic [15:0] o);
    bit hit;
    hit = m_field[14][m_col];
    case (m_mode)
      0: if (s) begin m_mode = 1; m_cyc = 0; end
      1: begin
        if (m_cyc < int'(TD)) begin
          if (hit) m_mode = 2;
          else begin
            if (l && !r) m_col = (m_col > 0) ? m_col - 1 : 0;
            else if (r && !l) m_col = (m_col < 15) ? m_col + 1 : 15;
            m_cyc++;
          end
        end else if (m_cyc == int'(TD)) begin
          for (int i = 15; i > 0; i--) m_field[i] = m_field[i-1];
          m_field[0] = o;
          if (m_score < 255) m_score++;
          m_cyc++;
        end else begin
          if (hit) m_mode = 2; else m_cyc = 0;
        end
      end
      default: if (s) model_reset();
    endcase
  endtask

  function automatic logic [255:0] grn_at(input int col);
    logic [255:0] g;
    g = '0;
    g[14*16 + col] = 1'b1;
    return g;
  endfunction

  function automatic logic [255:0] model_red();
    logic [255:0] g;
    for (int i = 0; i < 16; i++) g[i*16 +: 16] = m_field[i];
    return g;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".running"}, 256'(running), 256'(m_mode == 1));
    chk({tag, ".lost"},    256'(lost),    256'(m_mode == 2));
    chk({tag, ".row_req"}, 256'(row_req), 256'(m_mode == 1 && m_cyc == int'(TD)));
    chk({tag, ".score"},   256'(score),   256'(m_score));
    chk({tag, ".red"},     RedPixels,     model_red());
    chk({tag, ".grn"},     GrnPixels,     grn_at(m_col));
  endtask

  task automatic tick();
    logic s, l, r;
    logic [15:0] o;
    s = start; l = left; r = right; o = obstacle_row;
    @(posedge Clock);
    #1;
    model_step(s, l, r, o);
  endtask

  task automatic reset_dut();
    start = 0; left = 0; right = 0; obstacle_row = '0;
    reset = 0;
    repeat (2) @(posedge Clock);
    #1;
    reset = 1;
    model_reset();
  endtask

  // Waits for n row_req pulses, checks spacing, then clocks the shift edge.
  task automatic wait_steps(input int n);
    int seen, budget, last;
    seen = 0; budget = 0; last = -1;
    while (seen < n && budget < 40 * n) begin
      tick();
      budget++;
      if (row_req) begin
        if (last >= 0) chk("step_period", 256'(budget - last), 256'(TD + 2));
        last = budget;
        seen++;
      end
    end
    chk("step_wait_done", 256'(seen), 256'(n));
    tick();
  endtask

  typedef struct {
    logic st, l, r;
    logic exp_run;
    int   exp_col;
    int   exp_score;
    logic exp_rr;
  } vec_t;

  vec_t tbl [18];

  initial begin
    bit rr_seen;

    // Reset state and idle behaviour
    model_reset();
    reset_dut();
    rr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rr_seen |= row_req;
    end
    chk("rst.red",     RedPixels,      '0);
    chk("rst.grn",     GrnPixels,      grn_at(7));
    chk("rst.lost",    256'(lost),     '0);
    chk("rst.running", 256'(running),  '0);
    chk("rst.score",   256'(score),    '0);
    chk("rst.row_req_never", 256'(rr_seen), '0);

    // Table: moves, saturation, ignored inputs, move coinciding with tick
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 7, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 2, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1'b0};
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; left = tbl[i].l; right = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d.running", i), 256'(running), 256'(tbl[i].exp_run));
      chk($sformatf("tbl%0d.grn", i),     GrnPixels,     grn_at(tbl[i].exp_col));
      chk($sformatf("tbl%0d.score", i),   256'(score),   256'(tbl[i].exp_score));
      chk($sformatf("tbl%0d.row_req", i), 256'(row_req), 256'(tbl[i].exp_rr));
    end
    start = 0; left = 0; right = 0;

    // Start latency and field stepping
    reset_dut();
    obstacle_row = 16'h8001;
    start = 1; tick(); start = 0;
    chk("start.running", 256'(running), 256'(1));
    wait_steps(3);
    for (int r = 0; r < 3; r++) chk($sformatf("step3.red%0d", r), 256'(RedPixels[r]), 256'(16'h8001));
    chk("step3.red3", 256'(RedPixels[3]), '0);
    chk("step3.score", 256'(score), 256'(3));
    wait_steps(13);
    chk("step16.red15", 256'(RedPixels[15]), 256'(16'h8001));
    chk("step16.score", 256'(score), 256'(16));

    // Collision by shift, then frozen LOST state
    reset_dut();
    obstacle_row = 16'h0080;
    start = 1; tick(); start = 0;
    wait_steps(1);
    obstacle_row = '0;
    wait_steps(14);
    chk("shift.check_lost", 256'(lost), '0);
    chk("shift.red14", 256'(RedPixels[14]), 256'(16'h0080));
    tick();
    chk("shift.lost", 256'(lost), 256'(1));
    chk("shift.running", 256'(running), '0);
    chk("shift.score", 256'(score), 256'(15));
    left = 1; tick(); left = 0;
    right = 1; tick(); right = 0;
    repeat (8) tick();
    chk("frozen.lost", 256'(lost), 256'(1));
    chk("frozen.score", 256'(score), 256'(15));
    chk("frozen.red14", 256'(RedPixels[14]), 256'(16'h0080));
    chk("frozen.grn", GrnPixels, grn_at(7));
    compare_model("frozen");

    // Collision by move
    reset_dut();
    obstacle_row = 16'h0040;
    start = 1; tick(); start = 0;
    wait_steps(1);
    obstacle_row = '0;
    wait_steps(14);
    chk("move.no_hit_yet", 256'(lost), '0);
    tick();
    left = 1; tick(); left = 0;
    chk("move.grn6", GrnPixels, grn_at(6));
    chk("move.lost_k", 256'(lost), '0);
    tick();
    chk("move.lost_k1", 256'(lost), 256'(1));

    // Restart from LOST, then asynchronous reset mid-run
    start = 1; tick(); start = 0;
    chk("restart.lost", 256'(lost), '0);
    chk("restart.running", 256'(running), '0);
    chk("restart.red", RedPixels, '0);
    chk("restart.score", 256'(score), '0);
    chk("restart.grn", GrnPixels, grn_at(7));
    start = 1; tick(); start = 0;
    left = 1; tick(); left = 0;
    tick();
    chk("rerun.running", 256'(running), 256'(1));
    #2;
    reset = 0;
    #1;
    chk("async.running", 256'(running), '0);
    chk("async.lost", 256'(lost), '0);
    chk("async.grn", GrnPixels, grn_at(7));
    chk("async.score", 256'(score), '0);
    chk("async.red", RedPixels, '0);
    chk("async.row_req", 256'(row_req), '0);
    model_reset();

    // Randomized play against the reference model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 24) == 0);
      left  = ($urandom_range(0, 3) == 0);
      right = ($urandom_range(0, 3) == 0);
      obstacle_row = ($urandom_range(0, 2) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
      tick();
      compare_model("rand");
    end
    start = 0; left = 0; right = 0; obstacle_row = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
